// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control FSM (fetch/decode/execute/memory/write-back)
//
// Purpose: sequences each instruction through the multi-cycle datapath one
// step per clock, stalling in FETCH/MEM_RD/MEM_WR until mem_ready_i.
// Optional MULT/DIV support is compiled in with `define MC_CONTROL_MDU_EN.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   opcode_i, funct_i    IR[31:26], IR[5:0]
//   mem_ready_i          memory completes the current access this cycle
//   pc_write_o           unconditional PC load (Mealy on mem_ready_i in FETCH)
//   pc_write_cond_o      PC load qualified by ALU branch result
//   pc_source_o          00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   i_or_d_o             memory address: 0 PC, 1 ALUOut
//   mem_read_o, mem_write_o, ir_write_o   memory/IR strobes
//   reg_write_o, reg_dst_o, mem_to_reg_o  register file write controls
//   alu_src_a_o, alu_src_b_o, alu_op_o    ALU operand/operation selects
//   mdu_start_o          one-cycle MULT/DIV launch pulse
//   illegal_o            one-cycle pulse on an undecodable instruction
//   state_o              current state (debug)

module mc_control #(
   parameter int ALUOP_W    = 4,
   parameter int MDU_CYCLES = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [5:0]         opcode_i,
   input  logic [5:0]         funct_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               pc_write_cond_o,
   output logic [1:0]         pc_source_o,
   output logic               i_or_d_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               ir_write_o,
   output logic               reg_write_o,
   output logic [1:0]         reg_dst_o,
   output logic [1:0]         mem_to_reg_o,
   output logic               alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               mdu_start_o,
   output logic               illegal_o,
   output logic [3:0]         state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_WB_R     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_I     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_MDU_WAIT = 4'd12
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_ADDU = 4'b1010;
   localparam logic [3:0] OP_SUBU = 4'b1011;
   localparam logic [3:0] OP_BGTZ = 4'b1100;
   localparam logic [3:0] OP_BGEZ = 4'b1101;
   localparam logic [3:0] OP_BNE  = 4'b1110;
   localparam logic [3:0] OP_LUI  = 4'b1111;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_JAL   = 6'b000011;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] FN_JR     = 6'b001000;

   state_t     state_q, state_d;
   logic [3:0] r_aop, i_aop, b_aop;
   logic       r_ok, i_ok, b_ok;
   logic       is_jr, is_jal, is_mem, is_mdu;
   state_t     dec_next;
   logic       dec_ill;
   logic [3:0] aop;

   // ------------------------------------------------------------------
   // Instruction field decode
   // ------------------------------------------------------------------
   always_comb begin
      r_aop = OP_ADD;
      r_ok  = 1'b1;
      case (funct_i)
         6'b100000: r_aop = OP_ADD;
         6'b100001: r_aop = OP_ADDU;
         6'b100010: r_aop = OP_SUB;
         6'b100011: r_aop = OP_SUBU;
         6'b100100: r_aop = OP_AND;
         6'b100101: r_aop = OP_OR;
         6'b100111: r_aop = OP_NOR;
         6'b101010: r_aop = OP_SLT;
         6'b000000: r_aop = OP_SLL;
         6'b000010: r_aop = OP_SRL;
         6'b000011: r_aop = OP_SRA;
         default:   r_ok  = 1'b0;
      endcase

      i_aop = OP_ADD;
      i_ok  = 1'b1;
      case (opcode_i)
         6'b001000: i_aop = OP_ADD;
         6'b001001: i_aop = OP_ADDU;
         6'b001100: i_aop = OP_AND;
         6'b001101: i_aop = OP_OR;
         6'b001010: i_aop = OP_SLT;
         6'b001111: i_aop = OP_LUI;
         default:   i_ok  = 1'b0;
      endcase

      // bgez is REGIMM (opcode 000001); rt is not visible here
      b_aop = OP_SUB;
      b_ok  = 1'b1;
      case (opcode_i)
         6'b000100: b_aop = OP_SUB;
         6'b000101: b_aop = OP_BNE;
         6'b000111: b_aop = OP_BGTZ;
         6'b000001: b_aop = OP_BGEZ;
         default:   b_ok  = 1'b0;
      endcase

      is_jr  = (opcode_i == OPC_RTYPE) && (funct_i == FN_JR);
      is_jal = (opcode_i == OPC_JAL);
      is_mem = (opcode_i == OPC_LW) || (opcode_i == OPC_SW);
`ifdef MC_CONTROL_MDU_EN
      is_mdu = (opcode_i == OPC_RTYPE) &&
               ((funct_i == 6'b011000) || (funct_i == 6'b011010));
`else
      is_mdu = 1'b0;
`endif

      dec_next = S_FETCH;
      dec_ill  = 1'b0;
      if (opcode_i == OPC_RTYPE) begin
         if (r_ok)        dec_next = S_EXEC_R;
         else if (is_jr)  dec_next = S_JUMP;
         else if (is_mdu) dec_next = S_MDU_WAIT;
         else             dec_ill  = 1'b1;
      end else if (i_ok)   dec_next = S_EXEC_I;
      else if (is_mem)     dec_next = S_MEM_ADDR;
      else if (b_ok)       dec_next = S_BRANCH;
      else if (is_jal)     dec_next = S_JUMP;
      else                 dec_ill  = 1'b1;
   end

   // ------------------------------------------------------------------
   // MDU busy counter
   // ------------------------------------------------------------------
`ifdef MC_CONTROL_MDU_EN
   localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_DECODE && state_d == S_MDU_WAIT)
         cnt_d = MDU_LOAD;
      else if (state_q == S_MDU_WAIT && cnt_q != 8'd0)
         cnt_d = cnt_q - 8'd1;
   end
`else
   logic [7:0] unused_mdu_cycles;
   assign unused_mdu_cycles = 8'(MDU_CYCLES);
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE:   state_d = dec_next;
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: state_d = (opcode_i == OPC_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = mem_ready_i ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
`ifdef MC_CONTROL_MDU_EN
         S_MDU_WAIT: state_d = (cnt_q == 8'd0) ? S_FETCH : S_MDU_WAIT;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (forced to 0 while reset is held)
   // ------------------------------------------------------------------
   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_source_o     = 2'b00;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_write_o     = 1'b0;
      reg_dst_o       = 2'b00;
      mem_to_reg_o    = 2'b00;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      aop             = 4'b0000;
      mdu_start_o     = 1'b0;
      illegal_o       = 1'b0;
      if (!rst_i) begin
         case (state_q)
            S_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = 2'b01;
               aop         = OP_ADD;
               // IR/PC load only on the cycle the fetch completes
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
               alu_src_b_o = 2'b11;
               aop         = OP_ADD;
               illegal_o   = dec_ill;
            end
            S_EXEC_R: begin
               alu_src_a_o = 1'b1;
               aop         = r_aop;
            end
            S_WB_R: reg_write_o = 1'b1;
            S_EXEC_I: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               aop         = i_aop;
            end
            S_WB_I: begin
               reg_write_o = 1'b1;
               reg_dst_o   = 2'b01;
            end
            S_MEM_ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               aop         = OP_ADD;
            end
            S_MEM_RD: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
            end
            S_WB_MEM: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'b01;
               mem_to_reg_o = 2'b01;
            end
            S_MEM_WR: begin
               mem_write_o = 1'b1;
               i_or_d_o    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_o     = 1'b1;
               aop             = b_aop;
               pc_write_cond_o = 1'b1;
               pc_source_o     = 2'b01;
            end
            S_JUMP: begin
               pc_write_o = 1'b1;
               if (is_jal) begin
                  pc_source_o  = 2'b10;
                  reg_write_o  = 1'b1;
                  reg_dst_o    = 2'b10;
                  mem_to_reg_o = 2'b10;
               end else begin
                  pc_source_o  = 2'b11;
               end
            end
`ifdef MC_CONTROL_MDU_EN
            // counter still holds its load value only in the entry cycle
            S_MDU_WAIT: mdu_start_o = (cnt_q == MDU_LOAD);
`endif
            default: ;
         endcase
      end
   end

   assign alu_op_o = ALUOP_W'(aop);
   assign state_o  = rst_i ? 4'd0 : state_q;

endmodule
